// File: rtl/uart_pkg.sv
// Shared UART link constants: default baud divisor, frame layout and receiver state encoding.
// Imported by the receive front-end and by the command FSM that consumes its bytes.
package uart_pkg;

  localparam int UART_BR         = 434;
  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = UART_DATA_W + 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_t;

  // Counter width that never collapses to zero bits for tiny parameter values.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous level; the reset value is chosen by the
// caller so that an idle line reads as idle straight out of reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive front-end: start, DATA_W bits LSB-first, parity, stop; mid-bit sampling off a baud counter.
// rx_vld pulses one cycle after the stop sample (~10.5*BR+3 clk after the start edge); no backpressure.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int   BR         = UART_BR,
  parameter int   DATA_W     = UART_DATA_W,
  parameter logic PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_vld,
  output logic              parity_err,
  output logic              frame_err,
  output logic              rx_busy
);

  localparam int BR_CNT_W  = cnt_w(BR);
  localparam int BIT_CNT_W = cnt_w(DATA_W);
  localparam logic [BR_CNT_W-1:0]  BR_HALF  = BR_CNT_W'(BR / 2 - 1);
  localparam logic [BR_CNT_W-1:0]  BR_LAST  = BR_CNT_W'(BR - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_W - 1);

  logic                 w_rx_s;
  logic                 w_fall;
  logic                 w_bit_end;
  logic                 r_rx_d;
  uart_state_t          r_state;
  logic [BR_CNT_W-1:0]  r_br_cnt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [DATA_W-1:0]    r_shift;
  logic                 r_par;
  logic [DATA_W-1:0]    r_rx_data;
  logic                 r_rx_vld;
  logic                 r_parity_err;
  logic                 r_frame_err;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_d <= 1'b1;
    else        r_rx_d <= w_rx_s;
  end

  assign w_fall    = r_rx_d & ~w_rx_s;
  assign w_bit_end = (r_br_cnt == BR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_br_cnt     <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_rx_data    <= '0;
      r_rx_vld     <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state  <= ST_START;
            r_br_cnt <= '0;
          end
        end
        // Half a bit in, the start bit must still be low or the edge was a glitch.
        ST_START: begin
          if (r_br_cnt == BR_HALF) begin
            r_br_cnt  <= '0;
            r_bit_cnt <= '0;
            r_state   <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_br_cnt <= r_br_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_shift[r_bit_cnt] <= w_rx_s;
            r_br_cnt           <= '0;
            r_bit_cnt          <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) r_state <= ST_PARITY;
          end else begin
            r_br_cnt <= r_br_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_par    <= w_rx_s;
            r_br_cnt <= '0;
            r_state  <= ST_STOP;
          end else begin
            r_br_cnt <= r_br_cnt + 1'b1;
          end
        end
        // Completed frames always report, errors included; the consumer decides what to drop.
        ST_STOP: begin
          if (w_bit_end) begin
            r_rx_data    <= r_shift;
            r_parity_err <= (^{r_shift, r_par}) != PARITY_ODD;
            r_frame_err  <= ~w_rx_s;
            r_rx_vld     <= 1'b1;
            r_br_cnt     <= '0;
            r_state      <= w_rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            r_br_cnt <= r_br_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_vld     = r_rx_vld;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign rx_busy    = (r_state != ST_IDLE);

endmodule
